// File: rtl/combo_lock_ctrl.sv
// Four-button combination lock controller: collects four digits, opens on a match,
// counts consecutive failures and enforces a lockout period after MAX_FAIL misses.
module combo_lock_ctrl #(
  parameter logic [7:0]  CODE         = 8'hE4,
  parameter int unsigned OPEN_CYC     = 25_000_000,
  parameter int unsigned LOCKOUT_CYC  = 50_000_000,
  parameter int unsigned ENTRY_TO_CYC = 25_000_000,
  parameter int unsigned MAX_FAIL     = 3
) (
  input  logic       clk5,
  input  logic       reset,
  input  logic [3:0] btn_pulse,
  input  logic       lock_req,
  output logic       unlocked,
  output logic       lockout,
  output logic [2:0] digit_cnt,
  output logic [2:0] fail_cnt,
  output logic       err_pulse
);

  localparam int unsigned TimerW = 26;

  localparam logic [TimerW-1:0] OpenLast  = TimerW'(OPEN_CYC - 1);
  localparam logic [TimerW-1:0] LockLast  = TimerW'(LOCKOUT_CYC - 1);
  localparam logic [TimerW-1:0] EntryLast = TimerW'(ENTRY_TO_CYC - 1);
  localparam logic [2:0]        MaxFail   = 3'(MAX_FAIL);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ENTRY   = 2'd1;
  localparam logic [1:0] S_OPEN    = 2'd2;
  localparam logic [1:0] S_LOCKOUT = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              mis_q, mis_d;
  logic [2:0]        digit_q, digit_d;
  logic [2:0]        fail_q, fail_d;
  logic              err_q, err_d;
  logic              unlocked_q, unlocked_d;
  logic              lockout_q, lockout_d;

  logic       press;
  logic       onehot;
  logic [1:0] btn_idx;
  logic [1:0] code_digit;
  logic       digit_bad;
  logic [2:0] fail_inc;

  assign press  = |btn_pulse;
  assign onehot = $onehot(btn_pulse);

  always_comb begin
    btn_idx = 2'd0;
    case (btn_pulse)
      4'b0010: btn_idx = 2'd1;
      4'b0100: btn_idx = 2'd2;
      4'b1000: btn_idx = 2'd3;
      default: btn_idx = 2'd0;
    endcase
  end

  // digit_cnt is always 0 in IDLE, so it doubles as the position of the incoming digit.
  assign code_digit = 2'(CODE >> {digit_q[1:0], 1'b0});
  assign digit_bad  = !onehot || (btn_idx != code_digit);
  assign fail_inc   = fail_q + 3'd1;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    mis_d   = mis_q;
    digit_d = digit_q;
    fail_d  = fail_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (press) begin
          state_d = S_ENTRY;
          digit_d = 3'd1;
          mis_d   = digit_bad;
        end
      end

      S_ENTRY: begin
        if (press) begin
          timer_d = '0;
          if (digit_q == 3'd3) begin
            digit_d = 3'd0;
            mis_d   = 1'b0;
            if (mis_q || digit_bad) begin
              err_d   = 1'b1;
              fail_d  = fail_inc;
              state_d = (fail_inc == MaxFail) ? S_LOCKOUT : S_IDLE;
            end else begin
              fail_d  = 3'd0;
              state_d = S_OPEN;
            end
          end else begin
            digit_d = digit_q + 3'd1;
            mis_d   = mis_q || digit_bad;
          end
        end else if (timer_q == EntryLast) begin
          // Abandoned entry: discard silently without counting a failure.
          state_d = S_IDLE;
          digit_d = 3'd0;
          mis_d   = 1'b0;
        end
      end

      S_OPEN: begin
        if (lock_req || (timer_q == OpenLast)) begin
          state_d = S_IDLE;
        end
      end

      S_LOCKOUT: begin
        if (timer_q == LockLast) begin
          state_d = S_IDLE;
          fail_d  = 3'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
        digit_d = 3'd0;
        mis_d   = 1'b0;
      end
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end
  end

  assign unlocked_d = (state_d == S_OPEN);
  assign lockout_d  = (state_d == S_LOCKOUT);

  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      mis_q      <= 1'b0;
      digit_q    <= 3'd0;
      fail_q     <= 3'd0;
      err_q      <= 1'b0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      mis_q      <= mis_d;
      digit_q    <= digit_d;
      fail_q     <= fail_d;
      err_q      <= err_d;
      unlocked_q <= unlocked_d;
      lockout_q  <= lockout_d;
    end
  end

  assign unlocked  = unlocked_q;
  assign lockout   = lockout_q;
  assign digit_cnt = digit_q;
  assign fail_cnt  = fail_q;
  assign err_pulse = err_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Bench for combo_lock_ctrl: directed scenarios then random presses, every cycle compared
// against a queue-based reference model of the lock's rules.
module tb_combo_lock_ctrl;

  localparam int OpenCyc  = 20;
  localparam int LockCyc  = 30;
  localparam int EntryTo  = 10;
  localparam int MaxFail  = 3;
  localparam int CodeVal  = 'hE4;

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_OPEN  = 2;
  localparam int M_LOCK  = 3;

  logic       clk5;
  logic       reset;
  logic [3:0] btn_pulse;
  logic       lock_req;
  logic       unlocked;
  logic       lockout;
  logic [2:0] digit_cnt;
  logic [2:0] fail_cnt;
  logic       err_pulse;

  int n_assert;
  int n_fail;

  int          m_mode;
  int          m_q[$];
  int unsigned m_left;
  int          m_fail;
  bit          m_err;

  combo_lock_ctrl #(
    .CODE        (8'hE4),
    .OPEN_CYC    (OpenCyc),
    .LOCKOUT_CYC (LockCyc),
    .ENTRY_TO_CYC(EntryTo),
    .MAX_FAIL    (MaxFail)
  ) dut (
    .clk5     (clk5),
    .reset    (reset),
    .btn_pulse(btn_pulse),
    .lock_req (lock_req),
    .unlocked (unlocked),
    .lockout  (lockout),
    .digit_cnt(digit_cnt),
    .fail_cnt (fail_cnt),
    .err_pulse(err_pulse)
  );

  initial clk5 = 1'b0;
  always #5 clk5 = ~clk5;

  function automatic int code_dig(int k);
    return (CodeVal >> (2 * k)) & 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("unlocked", 32'(unlocked), 32'(m_mode == M_OPEN));
    check("lockout", 32'(lockout), 32'(m_mode == M_LOCK));
    check("digit_cnt", 32'(digit_cnt), 32'(m_q.size()));
    check("fail_cnt", 32'(fail_cnt), 32'(m_fail));
    check("err_pulse", 32'(err_pulse), 32'(m_err));
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_q.delete();
    m_left = 0;
    m_fail = 0;
    m_err  = 1'b0;
  endtask

  // Reference behaviour: digits kept as raw button words, judged only once four arrive.
  task automatic model_edge(input int btn, input bit lr);
    bit ok;
    m_err = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (btn != 0) begin
          m_q.delete();
          m_q.push_back(btn);
          m_mode = M_ENTRY;
          m_left = EntryTo;
        end
      end
      M_ENTRY: begin
        if (btn != 0) begin
          m_q.push_back(btn);
          if (m_q.size() == 4) begin
            ok = 1'b1;
            for (int k = 0; k < 4; k++) begin
              if (m_q[k] != (1 << code_dig(k))) ok = 1'b0;
            end
            m_q.delete();
            if (ok) begin
              m_mode = M_OPEN;
              m_left = OpenCyc;
              m_fail = 0;
            end else begin
              m_err = 1'b1;
              m_fail++;
              if (m_fail == MaxFail) begin
                m_mode = M_LOCK;
                m_left = LockCyc;
              end else begin
                m_mode = M_IDLE;
              end
            end
          end else begin
            m_left = EntryTo;
          end
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_IDLE;
            m_q.delete();
          end
        end
      end
      M_OPEN: begin
        m_left--;
        if (lr || m_left == 0) m_mode = M_IDLE;
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_mode = M_IDLE;
          m_fail = 0;
        end
      end
    endcase
  endtask

  task automatic step(input logic [3:0] btn, input bit lr);
    @(negedge clk5);
    btn_pulse = btn;
    lock_req  = lr;
    @(posedge clk5);
    model_edge(int'(btn), lr);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 1'b0);
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input int gap);
    step(a, 1'b0);
    idle(gap);
    step(b, 1'b0);
    idle(gap);
    step(c, 1'b0);
    idle(gap);
    step(d, 1'b0);
  endtask

  // Reset raised between edges; outputs must be cleared before the next rising edge.
  task automatic async_reset();
    #1;
    btn_pulse = 4'b0000;
    lock_req  = 1'b0;
    reset     = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk5);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] btn;
    bit         lr;
    n_assert  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    btn_pulse = 4'b0000;
    lock_req  = 1'b0;
    model_reset();

    #1;
    check_all();
    repeat (3) @(posedge clk5);
    #1;
    check_all();
    @(negedge clk5);
    reset = 1'b0;

    // Correct code, then let the open window expire.
    enter4(4'b0001, 4'b0010, 4'b0100, 4'b1000, 3);
    idle(OpenCyc + 3);

    // Three wrong attempts lead to lockout; presses and lock_req ignored there.
    for (int r = 0; r < 3; r++) begin
      enter4(4'b0010, 4'b0010, 4'b0100, 4'b1000, 1);
      idle(2);
    end
    for (int i = 0; i < LockCyc; i++) step(4'(1 << (i % 4)), i[0]);
    idle(3);

    // Entry timeout, then a multi-bit first digit.
    step(4'b0001, 1'b0);
    idle(EntryTo + 2);
    enter4(4'b0011, 4'b0010, 4'b0100, 4'b1000, 0);
    idle(2);

    // lock_req on the fifth open cycle, then lock_req in IDLE.
    enter4(4'b0001, 4'b0010, 4'b0100, 4'b1000, 0);
    idle(4);
    step(4'b0000, 1'b1);
    idle(2);
    step(4'b0000, 1'b1);
    idle(2);

    // Press coinciding with the timeout edge is still captured.
    step(4'b0001, 1'b0);
    idle(EntryTo - 1);
    step(4'b0010, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b1000, 1'b0);
    idle(OpenCyc + 2);

    // Async reset mid-lockout and mid-entry, then a clean unlock.
    for (int r = 0; r < 3; r++) enter4(4'b1000, 4'b0010, 4'b0100, 4'b1000, 0);
    idle(5);
    async_reset();
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    async_reset();
    enter4(4'b0001, 4'b0010, 4'b0100, 4'b1000, 1);
    idle(3);

    for (int i = 0; i < 1500; i++) begin
      btn = 4'b0000;
      if ($urandom_range(0, 99) < 35) begin
        if ($urandom_range(0, 9) < 7) btn = 4'(1 << code_dig(m_q.size()));
        else btn = 4'($urandom_range(1, 15));
      end
      lr = ($urandom_range(0, 7) == 0);
      step(btn, lr);
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
